// File: rtl/vec_loader.sv
// Serial-to-parallel operand assembler: packs VEC_SIZE lhs/rhs float pairs into two packed vectors.
// Optional VEC_LOADER_ZERO_PAD_EN adds in_last to close short vectors with +0.0 padding.
module vec_loader #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int VEC_SIZE   = 4,
  localparam int E = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int W = VEC_SIZE * E
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [E-1:0] in_lhs,
  input  logic [E-1:0] in_rhs,
`ifdef VEC_LOADER_ZERO_PAD_EN
  input  logic         in_last,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_lhs,
  output logic [W-1:0] out_rhs
);

  localparam int CW = (VEC_SIZE > 1) ? $clog2(VEC_SIZE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(VEC_SIZE - 1);

  typedef logic [VEC_SIZE-1:0][E-1:0] vec_t;

  logic [CW-1:0] cnt_q, cnt_d;
  vec_t          asm_lhs_q, asm_lhs_d, asm_rhs_q, asm_rhs_d;
  vec_t          out_lhs_q, out_lhs_d, out_rhs_q, out_rhs_d;
  logic          asm_full_q, asm_full_d;
  logic          out_valid_q, out_valid_d;

  logic accept, consume, pad, last_el, complete;
  vec_t fill_lhs, fill_rhs;

`ifdef VEC_LOADER_ZERO_PAD_EN
  assign pad = in_last;
`else
  assign pad = 1'b0;
`endif

  assign in_ready = !rst && !asm_full_q;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;
  assign last_el  = pad || (cnt_q == CNT_MAX);
  assign complete = accept && last_el;

  // Assembly contents with the incoming pair merged in; slots above a short-vector
  // terminator read as +0.0 so the forwarded vector is already padded.
  for (genvar g = 0; g < VEC_SIZE; g++) begin : g_slot
    logic hit, zero;
    assign hit  = (CW'(g) == cnt_q);
    assign zero = pad && (CW'(g) > cnt_q);
    assign fill_lhs[g] = hit ? in_lhs : (zero ? '0 : asm_lhs_q[g]);
    assign fill_rhs[g] = hit ? in_rhs : (zero ? '0 : asm_rhs_q[g]);
  end

  always_comb begin
    cnt_d       = cnt_q;
    asm_lhs_d   = asm_lhs_q;
    asm_rhs_d   = asm_rhs_q;
    asm_full_d  = asm_full_q;
    out_lhs_d   = out_lhs_q;
    out_rhs_d   = out_rhs_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      asm_lhs_d = fill_lhs;
      asm_rhs_d = fill_rhs;
      cnt_d     = last_el ? '0 : cnt_q + 1'b1;
    end

    if (complete) begin
      if (!out_valid_q || consume) begin
        out_lhs_d   = fill_lhs;
        out_rhs_d   = fill_rhs;
        out_valid_d = 1'b1;
      end else begin
        asm_full_d  = 1'b1;
      end
    end else if (asm_full_q && consume) begin
      out_lhs_d   = asm_lhs_q;
      out_rhs_d   = asm_rhs_q;
      asm_full_d  = 1'b0;
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      asm_lhs_q   <= '0;
      asm_rhs_q   <= '0;
      asm_full_q  <= 1'b0;
      out_lhs_q   <= '0;
      out_rhs_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      asm_lhs_q   <= asm_lhs_d;
      asm_rhs_q   <= asm_rhs_d;
      asm_full_q  <= asm_full_d;
      out_lhs_q   <= out_lhs_d;
      out_rhs_q   <= out_rhs_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_lhs   = out_lhs_q;
  assign out_rhs   = out_rhs_q;

endmodule

// File: tb/tb_vec_loader.sv
// Bench for vec_loader (VEC_SIZE=4, FP32): directed scenarios plus random traffic
// checked against a queue-of-vectors reference model.
module tb_vec_loader;
  localparam int VS = 4;
  localparam int E  = 32;
  localparam int W  = VS * E;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [E-1:0] in_lhs, in_rhs;
  logic [W-1:0] out_lhs, out_rhs;
  logic         last_sig;

  vec_loader #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .VEC_SIZE(VS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_lhs(in_lhs), .in_rhs(in_rhs),
`ifdef VEC_LOADER_ZERO_PAD_EN
    .in_last(last_sig),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_lhs(out_lhs), .out_rhs(out_rhs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;

  // Reference model: complete vectors held by the block (output first), the
  // partially assembled vector, and the last vector handed to the consumer.
  logic [2*W-1:0] vq[$];
  logic [E-1:0]   plhs[VS];
  logic [E-1:0]   prhs[VS];
  int             pcnt = 0;
  logic [2*W-1:0] last_out = '0;

  task automatic chk(input string tag, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [E-1:0] l, input logic [E-1:0] r,
                       input logic lst, input logic ordy);
    in_valid  = v;
    in_lhs    = l;
    in_rhs    = r;
    last_sig  = lst;
    out_ready = ordy;
  endtask

  // One clock: compare outputs against the model, advance the model, step past the edge.
  task automatic cyc();
    logic           exp_rdy, acc, con, lst;
    logic [2*W-1:0] exp_out;
    logic [W-1:0]   vl, vr;
    @(negedge clk);
    exp_rdy = !rst && (vq.size() < 2);
    exp_out = (vq.size() > 0) ? vq[0] : last_out;
    chk("in_ready", {{(2*W-1){1'b0}}, in_ready}, {{(2*W-1){1'b0}}, exp_rdy});
    chk("out_valid", {{(2*W-1){1'b0}}, out_valid}, {{(2*W-1){1'b0}}, vq.size() > 0});
    chk("out_data", {out_lhs, out_rhs}, exp_out);
    if (rst) begin
      vq.delete();
      pcnt     = 0;
      last_out = '0;
    end else begin
`ifdef VEC_LOADER_ZERO_PAD_EN
      lst = last_sig;
`else
      lst = 1'b0;
`endif
      acc = in_valid && exp_rdy;
      con = out_ready && (vq.size() > 0);
      if (con) last_out = vq.pop_front();
      if (acc) begin
        plhs[pcnt] = in_lhs;
        prhs[pcnt] = in_rhs;
        pcnt++;
        if (pcnt == VS || lst) begin
          vl = '0;
          vr = '0;
          for (int i = 0; i < pcnt; i++) begin
            vl[i*E +: E] = plhs[i];
            vr[i*E +: E] = prhs[i];
          end
          vq.push_back({vl, vr});
          pcnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc_n;
    logic [E-1:0] lv [4];
    lv[0] = 32'h3F800000; lv[1] = 32'h40000000; lv[2] = 32'h40400000; lv[3] = 32'h40800000;

    rst = 1'b1;
    drive(0, '0, '0, 0, 0);
    @(posedge clk);
    #1;
    cyc();
    chk("rst_out_lhs", {{W{1'b0}}, out_lhs}, '0);
    rst = 1'b0;

    // Single vector with out_ready high
    for (int i = 0; i < 4; i++) begin
      drive(1, lv[i], 32'h3F800000, 0, 1);
      cyc();
    end
    drive(0, '0, '0, 0, 1);
    chk("vec1_lhs", {{W{1'b0}}, out_lhs}, {{W{1'b0}}, 128'h40800000_40400000_40000000_3F800000});
    chk("vec1_rhs", {{W{1'b0}}, out_rhs}, {{W{1'b0}}, 128'h3F800000_3F800000_3F800000_3F800000});
    for (int i = 0; i < 3; i++) cyc();

    // Three back-to-back vectors
    for (int i = 0; i < 12; i++) begin
      drive(1, 32'h100 + i, 32'h200 + i, 0, 1);
      cyc();
    end
    drive(0, '0, '0, 0, 1);
    cyc();
    cyc();

    // Stall: out_ready low, 12 attempted pairs, only 8 fit
    acc_n = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 32'h1000 + acc_n, 32'h2000 + acc_n, 0, 0);
      if (in_ready) acc_n++;
      cyc();
    end
    chk("stall_accepts", {{(2*W-32){1'b0}}, 32'(acc_n)}, {{(2*W-32){1'b0}}, 32'd8});
    chk("stall_hold", {{W{1'b0}}, out_lhs}, {{W{1'b0}}, 128'h00001003_00001002_00001001_00001000});
    drive(0, '0, '0, 0, 1);
    cyc();
    drive(0, '0, '0, 0, 0);
    chk("stall_vec2", {{W{1'b0}}, out_lhs}, {{W{1'b0}}, 128'h00001007_00001006_00001005_00001004});
    chk("stall_rdy", {{(2*W-1){1'b0}}, in_ready}, {{(2*W-1){1'b0}}, 1'b1});
    cyc();
    drive(0, '0, '0, 0, 1);
    cyc();
    cyc();

    // Reset mid-vector
    drive(1, 32'hAAAA0000, 32'hBBBB0000, 0, 1);
    cyc();
    cyc();
    drive(0, '0, '0, 0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_mid_valid", {{(2*W-1){1'b0}}, out_valid}, '0);
    chk("rst_mid_data", {out_lhs, out_rhs}, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h3000 + i, 32'h4000 + i, 0, 1);
      cyc();
    end
    chk("rst_clean_vec", {{W{1'b0}}, out_lhs}, {{W{1'b0}}, 128'h00003003_00003002_00003001_00003000});
    drive(0, '0, '0, 0, 1);
    cyc();

`ifdef VEC_LOADER_ZERO_PAD_EN
    drive(1, 32'h3F800000, 32'h3F800000, 0, 1);
    cyc();
    drive(1, 32'h40000000, 32'h40000000, 1, 1);
    cyc();
    chk("zpad_lhs", {{W{1'b0}}, out_lhs}, {{W{1'b0}}, 128'h00000000_00000000_40000000_3F800000});
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h5000 + i, 32'h6000 + i, 0, 1);
      cyc();
    end
    chk("zpad_next", {{W{1'b0}}, out_lhs}, {{W{1'b0}}, 128'h00005003_00005002_00005001_00005000});
    drive(0, '0, '0, 0, 1);
    cyc();
`endif

    // Random traffic
    for (int ph = 0; ph < 24; ph++) begin
      int pv, pr;
      pv = $urandom_range(20, 100);
      pr = $urandom_range(0, 100);
      for (int c = 0; c < 60; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        drive($urandom_range(0, 99) < pv, $urandom, $urandom,
              $urandom_range(0, 7) == 0, $urandom_range(0, 99) < pr);
        cyc();
      end
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
